// File: rtl/upsamp_filter_if.sv
// upsamp_filter_if: sample, coefficient-write and output bus of the upsampling FIR filter
interface upsamp_filter_if;
  logic signed [3:0]  data_in;
  logic        [6:0]  addr;
  logic signed [7:0]  coefficient;
  logic               write_en;
  logic signed [11:0] filtered_output;
  modport master(output data_in, addr, coefficient, write_en, input filtered_output);
  modport slave(input data_in, addr, coefficient, write_en, output filtered_output);
endinterface

// File: rtl/upsamp_filter.sv
// upsamp_filter: zero-stuffing upsampler by L followed by an NTAPS-tap FIR with writable coefficients
module upsamp_filter #(
  parameter int L     = 4,
  parameter int NTAPS = 71
) (
  input logic            clk,
  input logic            rst,
  upsamp_filter_if.slave bus
);
  logic        [1:0]  phase;
  logic signed [3:0]  u;
  logic signed [3:0]  d [NTAPS];
  logic signed [7:0]  c [NTAPS] = '{default: '0};
  logic signed [19:0] acc;
  logic signed [11:0] sat;
  always_comb begin
    acc = '0;
    for (int k = 0; k < NTAPS; k++) acc = acc + 20'(d[k]) * 20'(c[k]);
    sat = (acc > 2047) ? 12'h7FF : (acc < -2048) ? 12'h800 : acc[11:0];
  end
  // addr is taken as a plain 7-bit index so that all taps 0..NTAPS-1 stay reachable
  always_ff @(posedge clk)
    if (bus.write_en && bus.addr <= 7'(NTAPS - 1)) c[bus.addr] <= bus.coefficient;
  always_ff @(posedge clk) begin
    if (rst) begin
      phase               <= '0;
      u                   <= '0;
      d                   <= '{default: '0};
      bus.filtered_output <= '0;
    end else begin
      phase               <= (phase == 2'(L - 1)) ? 2'd0 : phase + 2'd1;
      u                   <= (phase == 2'd0) ? bus.data_in : 4'sd0;
      d[0]                <= u;
      for (int k = 1; k < NTAPS; k++) d[k] <= d[k-1];
      bus.filtered_output <= sat;
    end
  end
endmodule

// File: tb/tb_upsamp_filter.sv
// tb_upsamp_filter: directed scoreboard bench for upsamp_filter
module tb_upsamp_filter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  upsamp_filter_if bus();
  upsamp_filter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int cm [71];
  int hb [73];
  int ph = 0;
  int exp_q [$];
  function automatic int sat(int v);
    return (v > 2047) ? 2047 : (v < -2048) ? -2048 : v;
  endfunction
  function automatic int outv();
    return int'(bus.filtered_output);
  endfunction
  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  // hb[j] holds the upsampled value captured j+1 edges before the coming edge
  task automatic step(input logic r, input int din, input logic we = 1'b0, input int a = 0, input int co = 0);
    int e;
    logic signed [11:0] obs, expv;
    e = 0;
    rst = r;
    bus.data_in = 4'(din);
    bus.write_en = we;
    bus.addr = 7'(a);
    bus.coefficient = 8'(co);
    for (int k = 0; k < 71; k++) e += cm[k] * hb[k+1];
    exp_q.push_back(r ? 0 : sat(e));
    if (r) begin
      hb = '{default: 0};
      ph = 0;
    end else begin
      for (int j = 72; j > 0; j--) hb[j] = hb[j-1];
      hb[0] = (ph == 0) ? int'(bus.data_in) : 0;
      ph = (ph + 1) % 4;
    end
    if (we && a >= 0 && a <= 70) cm[a] = int'(bus.coefficient);
    @(posedge clk);
    #1;
    obs = bus.filtered_output;
    expv = 12'(exp_q.pop_front());
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL stream observed=%0d expected=%0d", obs, expv);
    end
  endtask
  task automatic steady(input string tag, input int din, input int sign);
    int s, v;
    s = 0;
    for (int j = 0; j < 4; j++) begin
      step(1'b0, din);
      v = outv() * sign;
      s += v;
      chk(tag, (v == 612 || v == 630 || v == 648 || v == 595) ? 1 : 0, 1);
    end
    chk(tag, s * sign, 2485 * sign);
  endtask
  initial begin
    cm = '{default: 0};
    hb = '{default: 0};
    for (int i = 0; i <= 70; i++) step(1'b1, 0, 1'b1, i, i);
    step(1'b1, 0, 1'b1, 100, 85);
    step(1'b1, 0);
    for (int j = 0; j < 80; j++) step(1'b0, (j == 0) ? 1 : (j % 4 == 0) ? 0 : 7);
    for (int j = 0; j < 100; j++) step(1'b0, 1);
    steady("step_pos", 1, 1);
    step(1'b1, 1);
    chk("midrst_zero", outv(), 0);
    for (int j = 0; j < 3; j++) step(1'b0, 1);
    chk("midrst_first", outv(), 0);
    step(1'b0, 1);
    chk("midrst_c1", outv(), 1);
    for (int j = 0; j < 100; j++) step(1'b0, 1);
    for (int j = 0; j < 100; j++) step(1'b0, 15);
    steady("step_neg", 15, -1);
    for (int i = 0; i <= 70; i++) step(1'b1, 0, 1'b1, i, 127);
    for (int j = 0; j < 80; j++) step(1'b0, 7);
    chk("sat_pos", outv(), 2047);
    for (int j = 0; j < 80; j++) step(1'b0, 8);
    chk("sat_neg", outv(), -2048);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
